// File: rtl/vram_px_arbiter.sv
// Shares one single-port pixel VRAM between the renderer (absolute priority) and a CPU requester.
// Latency: renderer read data 1 cycle after request; CPU access at least 2 cycles from start to done.
// Backpressure: renderer never stalls. A CPU access waits in PEND while gpu_req is high, and cpu_start is ignored while busy.
module vram_px_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic [DATA_W-1:0] gpu_q,
    output logic              gpu_valid,
    input  logic              cpu_start,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {IDLE, PEND, CPLT} state_t;

    localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic                hold_we_q, hold_we_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_d_q, hold_d_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic                starved_q, starved_d;
    logic [DATA_W-1:0]   cpu_q_q, cpu_q_d;
    logic                gpu_valid_q, gpu_valid_d;
    logic                grant;

    // Next-state logic for the CPU access FSM, wait counter and registered outputs.
    always_comb begin
        state_d     = state_q;
        hold_we_d   = hold_we_q;
        hold_addr_d = hold_addr_q;
        hold_d_d    = hold_d_q;
        wait_cnt_d  = wait_cnt_q;
        starved_d   = starved_q;
        cpu_q_d     = cpu_q_q;
        gpu_valid_d = gpu_req;
        grant       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_start) begin
                    hold_we_d   = cpu_we;
                    hold_addr_d = cpu_addr;
                    hold_d_d    = cpu_d;
                    wait_cnt_d  = 16'd0;
                    starved_d   = 1'b0;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (gpu_req) begin
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (wait_cnt_d >= LIMIT) begin
                        starved_d = 1'b1;
                    end
                end else begin
                    grant   = 1'b1;
                    state_d = CPLT;
                end
            end
            CPLT: begin
                // ram_q now carries the data addressed in the grant cycle.
                if (!hold_we_q) begin
                    cpu_q_d = ram_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over everything, including a grant in this very cycle,
        // so an access interrupted by reset never reaches the RAM.
        if (reset) begin
            state_d     = IDLE;
            hold_we_d   = 1'b0;
            hold_addr_d = '0;
            hold_d_d    = '0;
            wait_cnt_d  = 16'd0;
            starved_d   = 1'b0;
            cpu_q_d     = '0;
            gpu_valid_d = 1'b0;
            grant       = 1'b0;
        end
    end

    // State and holding registers.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        hold_we_q   <= hold_we_d;
        hold_addr_q <= hold_addr_d;
        hold_d_q    <= hold_d_d;
        wait_cnt_q  <= wait_cnt_d;
        starved_q   <= starved_d;
        cpu_q_q     <= cpu_q_d;
        gpu_valid_q <= gpu_valid_d;
    end

    // RAM port mux: renderer owns the port unless the CPU is granted this cycle.
    always_comb begin
        ram_addr = grant ? hold_addr_q : gpu_addr;
        ram_d    = hold_d_q;
        ram_we   = grant & hold_we_q;
    end

    assign gpu_q       = ram_q;
    assign gpu_valid   = gpu_valid_q;
    assign cpu_q       = cpu_q_q;
    assign cpu_busy    = (state_q != IDLE);
    assign cpu_done    = (state_q == CPLT);
    assign cpu_starved = starved_q;

endmodule

// File: tb/tb_vram_px_arbiter.sv
module tb_vram_px_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int LIMIT = 8;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          gpu_req;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_q;
    logic          gpu_valid;
    logic          cpu_start, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_d;
    logic [DW-1:0] cpu_q;
    logic          cpu_busy, cpu_done, cpu_starved;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q = 8'h00;

    int n_checks = 0;
    int n_err    = 0;

    vram_px_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_q(gpu_q), .gpu_valid(gpu_valid),
        .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_starved(cpu_starved),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port VRAM macro with 1-cycle registered read.
    logic [DW-1:0] ram_mem [0:MEMSZ-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_d;
        ram_q <= ram_mem[ram_addr];
    end

    // Transaction-level reference model: expected memory contents plus one
    // outstanding CPU access described by flags and a wait count.
    logic [DW-1:0] ref_mem [0:MEMSZ-1];
    bit            m_busy, m_done_now, m_we, m_starved, m_prev_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_d, m_rdat, m_cpu_q, m_prev_dat;
    int            m_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done_now = 0; m_starved = 0; m_prev_req = 0;
        m_cpu_q = '0; m_wait = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check every output
    // against the model, then advance the model to what the rising edge does.
    task automatic step(input logic r, input logic g, input logic [AW-1:0] ga,
                        input logic cs, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd);
        bit exp_grant;
        @(negedge clk);
        reset = r; gpu_req = g; gpu_addr = ga;
        cpu_start = cs; cpu_we = cw; cpu_addr = ca; cpu_d = cd;
        #1;
        exp_grant = m_busy && !m_done_now && !g && !r;
        chk("m_busy",    {31'd0, cpu_busy},  {31'd0, m_busy});
        chk("m_done",    {31'd0, cpu_done},  {31'd0, m_done_now});
        chk("m_ram_we",  {31'd0, ram_we},    {31'd0, exp_grant && m_we});
        chk("m_ram_addr", 32'(ram_addr), exp_grant ? 32'(m_addr) : 32'(ga));
        if (exp_grant && m_we) chk("m_ram_d", 32'(ram_d), 32'(m_d));
        chk("m_gpu_valid", {31'd0, gpu_valid}, {31'd0, m_prev_req});
        if (m_prev_req) chk("m_gpu_q", 32'(gpu_q), 32'(m_prev_dat));
        chk("m_cpu_q",   32'(cpu_q), 32'(m_cpu_q));
        chk("m_starved", {31'd0, cpu_starved}, {31'd0, m_starved});

        if (r) begin
            model_reset();
        end else begin
            m_prev_req = g;
            if (g) m_prev_dat = ref_mem[ga];
            if (m_done_now) begin
                if (!m_we) m_cpu_q = m_rdat;
                m_busy = 0; m_done_now = 0;
            end else if (m_busy) begin
                if (exp_grant) begin
                    if (m_we) ref_mem[m_addr] = m_d;
                    else      m_rdat = ref_mem[m_addr];
                    m_done_now = 1;
                end else begin
                    if (m_wait < 65535) m_wait++;
                    if (m_wait >= LIMIT) m_starved = 1;
                end
            end else if (cs) begin
                m_busy = 1; m_we = cw; m_addr = ca; m_d = cd;
                m_wait = 0; m_starved = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic rst, greq; logic [AW-1:0] ga;
        logic cs, cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
        logic ewe; logic [AW-1:0] eaddr; logic [DW-1:0] ed;
        logic ebusy, edone, evld; logic [DW-1:0] eq;
    } vec_t;

    vec_t vecs [0:16];

    initial begin
        // rst greq ga | cs cw ca cd | we addr d | busy done vld | cpu_q
        vecs[0]  = '{0,0,0,      0,0,0,0,         0,0,0,         0,0,0, 0};
        vecs[1]  = '{0,0,0,      1,1,'h10,'h5A,   0,0,0,         0,0,0, 0};
        vecs[2]  = '{0,0,0,      0,0,0,0,         1,'h10,'h5A,   1,0,0, 0};
        vecs[3]  = '{0,0,0,      0,0,0,0,         0,0,0,         1,1,0, 0};
        vecs[4]  = '{0,0,0,      1,0,'h10,0,      0,0,0,         0,0,0, 0};
        vecs[5]  = '{0,0,0,      0,0,0,0,         0,'h10,0,      1,0,0, 0};
        vecs[6]  = '{0,0,0,      0,0,0,0,         0,0,0,         1,1,0, 0};
        vecs[7]  = '{0,0,0,      0,0,0,0,         0,0,0,         0,0,0, 'h5A};
        vecs[8]  = '{0,0,0,      1,1,'h20,'h11,   0,0,0,         0,0,0, 'h5A};
        vecs[9]  = '{0,1,'h300,  1,1,'h21,'h22,   0,'h300,0,     1,0,0, 'h5A};
        vecs[10] = '{0,0,0,      0,0,0,0,         1,'h20,'h11,   1,0,1, 'h5A};
        vecs[11] = '{0,0,0,      1,1,'h22,'h33,   0,0,0,         1,1,0, 'h5A};
        vecs[12] = '{0,0,0,      0,0,0,0,         0,0,0,         0,0,0, 'h5A};
        vecs[13] = '{0,0,0,      1,1,'h30,'h77,   0,0,0,         0,0,0, 'h5A};
        vecs[14] = '{0,1,'h30,   0,0,0,0,         0,'h30,0,      1,0,0, 'h5A};
        vecs[15] = '{1,0,0,      0,0,0,0,         0,0,0,         1,0,1, 'h5A};
        vecs[16] = '{0,0,0,      0,0,0,0,         0,0,0,         0,0,0, 0};

        for (int i = 0; i < MEMSZ; i++) begin
            ram_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
        end
        reset = 1; gpu_req = 0; gpu_addr = '0;
        cpu_start = 0; cpu_we = 0; cpu_addr = '0; cpu_d = '0;
        model_reset();
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Directed vectors: write/read round trip, ignored starts, reset in PEND.
        for (int i = 0; i <= 16; i++) begin
            step(vecs[i].rst, vecs[i].greq, vecs[i].ga, vecs[i].cs,
                 vecs[i].cw, vecs[i].ca, vecs[i].cd);
            chk($sformatf("v%0d_we", i),   {31'd0, ram_we},    {31'd0, vecs[i].ewe});
            chk($sformatf("v%0d_addr", i), 32'(ram_addr),      32'(vecs[i].eaddr));
            if (vecs[i].ewe) chk($sformatf("v%0d_d", i), 32'(ram_d), 32'(vecs[i].ed));
            chk($sformatf("v%0d_busy", i), {31'd0, cpu_busy},  {31'd0, vecs[i].ebusy});
            chk($sformatf("v%0d_done", i), {31'd0, cpu_done},  {31'd0, vecs[i].edone});
            chk($sformatf("v%0d_vld", i),  {31'd0, gpu_valid}, {31'd0, vecs[i].evld});
            chk($sformatf("v%0d_cpuq", i), 32'(cpu_q),         32'(vecs[i].eq));
        end
        // Location 0x30 must be untouched by the access that reset dropped.
        chk("rst_drop_mem", 32'(ram_mem['h30]), 32'(8'h30 ^ 8'h00 ^ 8'hA5));
        chk("ign_start_mem", 32'(ram_mem['h21]), 32'(8'h21 ^ 8'hA5));

        // Starvation: read held off for 20 cycles, flag from the 9th waiting cycle.
        step(0, 0, '0, 1, 0, 'h10, '0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, AW'(i), 0, 0, '0, '0);
            chk($sformatf("starve_w%0d", i), {31'd0, cpu_starved}, {31'd0, i >= 9});
            chk($sformatf("starve_done%0d", i), {31'd0, cpu_done}, 32'd0);
        end
        step(0, 0, '0, 0, 0, '0, '0);
        chk("starve_grant_addr", 32'(ram_addr), 32'h10);
        step(0, 0, '0, 0, 0, '0, '0);
        chk("starve_done", {31'd0, cpu_done}, 32'd1);
        chk("starve_sticky", {31'd0, cpu_starved}, 32'd1);
        step(0, 0, '0, 1, 1, 'h40, 8'h01);
        chk("starve_cpuq", 32'(cpu_q), 32'h5A);
        chk("starve_hold", {31'd0, cpu_starved}, 32'd1);
        step(0, 0, '0, 0, 0, '0, '0);
        chk("starve_clear", {31'd0, cpu_starved}, 32'd0);
        idle(2);

        // Renderer ramp with a CPU read pending underneath.
        step(0, 0, '0, 1, 0, 'h22, '0);
        for (int i = 0; i < 100; i++) begin
            step(0, 1, AW'(i), 0, 0, '0, '0);
            chk($sformatf("ramp_we%0d", i), {31'd0, ram_we}, 32'd0);
            chk($sformatf("ramp_done%0d", i), {31'd0, cpu_done}, 32'd0);
        end
        step(0, 0, '0, 0, 0, '0, '0);
        step(0, 0, '0, 0, 0, '0, '0);
        chk("ramp_done_after", {31'd0, cpu_done}, 32'd1);
        step(0, 0, '0, 0, 0, '0, '0);
        chk("ramp_cpuq", 32'(cpu_q), 32'(8'h22 ^ 8'hA5));

        // Alternating renderer traffic with back-to-back CPU starts, then random traffic.
        for (int i = 0; i < 2200; i++) begin
            logic r, g, cs, cw;
            r  = (i >= 200) && ($urandom_range(0, 399) == 0);
            g  = (i < 200) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            cs = (i < 200) ? 1'b1 : ($urandom_range(0, 2) == 0);
            cw = 1'($urandom_range(0, 1));
            step(r, g, AW'($urandom_range(0, 63)), cs, cw,
                 AW'($urandom_range(0, 63)), DW'($urandom_range(0, 255)));
        end
        idle(4);
        for (int i = 0; i < 64; i++)
            chk($sformatf("final_mem%0d", i), 32'(ram_mem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
